// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset defaults, opcodes, instruction field positions
// and the IF/ID register layout.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000; // sll $0,$0,0

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: enable, synchronous flush to a constant, async active-low reset.
module pipe_reg #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RST_VAL   = '0,
    parameter logic [W-1:0]   FLUSH_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Hold when disabled; flush takes precedence over new data when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (en) begin
            if (flush) begin
                r_q <= FLUSH_VAL;
            end else begin
                r_q <= d;
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, next-PC select, IF/ID register and stall/flush counters.
//
// Enable semantics: pc_write_en / ifid_write_en are level "advance" strobes from the
// stall unit; a register updates on an edge only when its enable is 1, otherwise it
// holds. A redirect (jump or branch_taken) is acted on only in a cycle that advances
// the PC; during a stall the ID instruction keeps asserting it until it is honoured.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_write_en,
    input  logic        ifid_write_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [5:0]  id_op,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam ifid_t IFID_BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    ifid_t       w_ifid_d;
    ifid_t       w_ifid_q;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    assign w_pc4      = w_pc + 32'd4;   // wraps modulo 2^32
    assign w_redirect = pc_write_en & (jump | branch_taken);

    // Next-PC select: jump beats branch beats sequential.
    always_comb begin
        w_next_pc = w_pc4;
        if (jump) begin
            w_next_pc = jump_target;
        end else if (branch_taken) begin
            w_next_pc = branch_target;
        end
    end

    pipe_reg #(
        .W        (32),
        .RST_VAL  (RESET_PC),
        .FLUSH_VAL(RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst_n(reset_n),
        .en   (pc_write_en),
        .flush(1'b0),
        .d    (w_next_pc),
        .q    (w_pc)
    );

    assign w_ifid_d = '{pc4: w_pc4, instr: imem_rdata, valid: 1'b1};

    pipe_reg #(
        .W        ($bits(ifid_t)),
        .RST_VAL  (IFID_BUBBLE),
        .FLUSH_VAL(IFID_BUBBLE)
    ) u_ifid_reg (
        .clk  (clk),
        .rst_n(reset_n),
        .en   (ifid_write_en),
        .flush(w_redirect),
        .d    (w_ifid_d),
        .q    (w_ifid_q)
    );

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= 16'h0;
        end else if (!pc_write_en && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    // Saturating count of honoured redirects (a jump+branch pair counts once).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_count <= 16'h0;
        end else if (w_redirect && (r_flush_count != CNT_MAX)) begin
            r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign imem_addr   = w_pc;
    assign if_id_pc4   = w_ifid_q.pc4;
    assign if_id_instr = w_ifid_q.instr;
    assign if_id_valid = w_ifid_q.valid;
    assign id_op       = w_ifid_q.instr[OP_MSB:OP_LSB];
    assign id_rs       = w_ifid_q.instr[RS_MSB:RS_LSB];
    assign id_rt       = w_ifid_q.instr[RT_MSB:RT_LSB];
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int total;
    int bad;

    logic        use_override;
    logic [31:0] override_word;

    // imem[i] = i, optionally replaced by a fixed word for field-slice checks.
    assign imem_rdata = use_override ? override_word : (imem_addr >> 2);

    fetch_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_write_en  (pc_write_en),
        .ifid_write_en(ifid_write_en),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_pc4    (if_id_pc4),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The stall unit always drives both enables together.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (pc_write_en === ifid_write_en) else begin
                bad = bad + 1;
                $error("FAIL enable_pair: pc_write_en=%b ifid_write_en=%b", pc_write_en, ifid_write_en);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, "_addr"},  imem_addr, addr);
        check({tag, "_instr"}, if_id_instr, instr);
        check({tag, "_pc4"},   if_id_pc4, pc4);
        check({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, valid});
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        use_override  = 1'b0;
        override_word = 32'h0;

        // Reset state
        #22;
        check_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst_stall", {16'h0, stall_count}, 32'h0);
        check("rst_flush", {16'h0, flush_count}, 32'h0);
        reset_n = 1'b1;

        // Free run: after edge k, addr=4k and IF/ID holds word k-1
        for (int k = 1; k <= 4; k++) begin
            step();
            check_ifid("run", 32'(4 * k), 32'(k - 1), 32'(4 * k), 1'b1);
        end

        // Load-use stall for two cycles at PC=0x10
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        step();
        check_ifid("stall1", 32'h10, 32'h3, 32'h10, 1'b1);
        check("stall1_cnt", {16'h0, stall_count}, 32'd1);
        step();
        check_ifid("stall2", 32'h10, 32'h3, 32'h10, 1'b1);
        check("stall2_cnt", {16'h0, stall_count}, 32'd2);
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        step();
        check_ifid("resume", 32'h14, 32'h4, 32'h14, 1'b1);
        step();
        check_ifid("pre_br", 32'h18, 32'h5, 32'h18, 1'b1);

        // Branch taken at PC=0x18 to 0x40
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        check_ifid("br_bub", 32'h40, 32'h0, 32'h0, 1'b0);
        check("br_flush", {16'h0, flush_count}, 32'd1);
        branch_taken = 1'b0;
        step();
        check_ifid("br_tgt", 32'h44, 32'h10, 32'h44, 1'b1);

        // Jump and branch together: jump wins, single flush
        jump          = 1'b1;
        jump_target   = 32'h80;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        check_ifid("jb_bub", 32'h80, 32'h0, 32'h0, 1'b0);
        check("jb_flush", {16'h0, flush_count}, 32'd2);
        jump         = 1'b0;
        branch_taken = 1'b0;
        step();
        check_ifid("jb_tgt", 32'h84, 32'h20, 32'h84, 1'b1);

        // Branch during a stall is ignored until the stall releases
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        check_ifid("bst_hold", 32'h84, 32'h20, 32'h84, 1'b1);
        check("bst_flush_hold", {16'h0, flush_count}, 32'd2);
        check("bst_stall", {16'h0, stall_count}, 32'd3);
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        step();
        check_ifid("bst_bub", 32'h100, 32'h0, 32'h0, 1'b0);
        check("bst_flush", {16'h0, flush_count}, 32'd3);
        branch_taken = 1'b0;
        step();
        check_ifid("bst_tgt", 32'h104, 32'h40, 32'h104, 1'b1);

        // Field slices: lw with rs=5, rt=6
        use_override  = 1'b1;
        override_word = 32'h8CA6_0000;
        step();
        check("slice_instr", if_id_instr, 32'h8CA6_0000);
        check("slice_op", {26'h0, id_op}, 32'h23);
        check("slice_rs", {27'h0, id_rs}, 32'd5);
        check("slice_rt", {27'h0, id_rt}, 32'd6);
        use_override = 1'b0;

        // PC wrap from 0xFFFF_FFFC
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        check_ifid("wrap_bub", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        check("wrap_flush", {16'h0, flush_count}, 32'd4);
        jump = 1'b0;
        step();
        check_ifid("wrap", 32'h0, 32'h3FFF_FFFF, 32'h0, 1'b1);
        check("wrap_op", {26'h0, id_op}, 32'h0F);

        // Stall counter saturation: 3 -> 0xFFFF, then stays
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        repeat (65532) step();
        check("sat_reach", {16'h0, stall_count}, 32'hFFFF);
        step();
        step();
        check("sat_hold", {16'h0, stall_count}, 32'hFFFF);
        check("sat_addr", imem_addr, 32'h0);

        // Asynchronous reset mid-stall with a pending branch
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        #2;
        reset_n = 1'b0;
        #1;
        check_ifid("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        check("arst_stall", {16'h0, stall_count}, 32'h0);
        check("arst_flush", {16'h0, flush_count}, 32'h0);
        @(negedge clk);
        reset_n       = 1'b1;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        branch_taken  = 1'b0;
        step();
        check_ifid("post_rst", 32'h4, 32'h0, 32'h4, 1'b1);
        check("post_rst_flush", {16'h0, flush_count}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
